// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute, memory, writeback.
// Owns the memory-ack timeout and the sticky trap state; strobes are decoded from state.
module rv32i_mc_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_opcode,
  input  logic [3:0] i_alu_op,
  input  logic       i_br_taken,
  input  logic       i_imem_ack,
  input  logic       i_dmem_ack,
  output logic       o_imem_req,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic       o_pc_sel,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  output logic       o_rf_we,
  output logic       o_wb_sel,
  output logic       o_retire,
  output logic       o_trap,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [3:0] ALU_ILL   = 4'hF;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] wait_cnt;

  logic is_alu, is_load, is_store, is_branch, is_legal, timed_out;

  // i_opcode comes from IR, which holds steady from DECODE until the next fetch ack.
  assign is_alu    = (i_opcode == OP_R) || (i_opcode == OP_I);
  assign is_load   = (i_opcode == OP_LOAD);
  assign is_store  = (i_opcode == OP_STORE);
  assign is_branch = (i_opcode == OP_BRANCH);
  assign is_legal  = is_alu || is_load || is_store || is_branch;
  assign timed_out = (wait_cnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments only; the later
  // assignment to wait_cnt in the same edge overrides the default clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_FETCH: begin
          if (i_imem_ack)     state <= S_DECODE;
          else if (timed_out) state <= S_TRAP;
          else                wait_cnt <= wait_cnt + 1'b1;
        end
        S_DECODE: state <= is_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (is_branch)                  state <= S_FETCH;
          else if (is_load || is_store)   state <= S_MEM;
          else if (is_alu)                state <= (i_alu_op == ALU_ILL) ? S_TRAP : S_WB;
          else                            state <= S_TRAP;
        end
        S_MEM: begin
          if (i_dmem_ack)     state <= is_store ? S_FETCH : S_WB;
          else if (timed_out) state <= S_TRAP;
          else                wait_cnt <= wait_cnt + 1'b1;
        end
        S_WB:    state <= S_FETCH;
        default: state <= S_TRAP;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    o_imem_req = 1'b0;
    o_ir_we    = 1'b0;
    o_pc_we    = 1'b0;
    o_pc_sel   = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_rf_we    = 1'b0;
    o_wb_sel   = 1'b0;
    o_retire   = 1'b0;
    o_trap     = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          o_imem_req = 1'b1;
          o_ir_we    = i_imem_ack;
        end
        S_EXEC: begin
          o_pc_we  = is_branch;
          o_pc_sel = is_branch & i_br_taken;
          o_retire = is_branch;
        end
        S_MEM: begin
          o_dmem_req = 1'b1;
          o_dmem_we  = is_store;
          o_pc_we    = is_store & i_dmem_ack;
          o_retire   = is_store & i_dmem_ack;
        end
        S_WB: begin
          o_rf_we  = 1'b1;
          o_wb_sel = is_load;
          o_pc_we  = 1'b1;
          o_retire = 1'b1;
        end
        S_TRAP:  o_trap = 1'b1;
        default: ;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_rv32i_mc_ctrl.sv
// Bench for rv32i_mc_ctrl: builds each instruction's expected per-cycle output trace from
// its class and ack waits, drives randomized instructions, and compares every cycle.
module tb_rv32i_mc_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] i_opcode;
  logic [3:0] i_alu_op;
  logic       i_br_taken, i_imem_ack, i_dmem_ack;
  logic       o_imem_req, o_ir_we, o_pc_we, o_pc_sel, o_dmem_req, o_dmem_we;
  logic       o_rf_we, o_wb_sel, o_retire, o_trap;
  logic [2:0] o_state;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [2:0] state;
    logic imem_req, ir_we, pc_we, pc_sel, dmem_req, dmem_we, rf_we, wb_sel, retire, trap;
  } exp_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;

  rv32i_mc_ctrl #(.TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_opcode(i_opcode), .i_alu_op(i_alu_op),
    .i_br_taken(i_br_taken), .i_imem_ack(i_imem_ack), .i_dmem_ack(i_dmem_ack),
    .o_imem_req(o_imem_req), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we), .o_pc_sel(o_pc_sel),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_rf_we(o_rf_we), .o_wb_sel(o_wb_sel),
    .o_retire(o_retire), .o_trap(o_trap), .o_state(o_state)
  );

  always #5 clk = ~clk;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit legal(input logic [6:0] op);
    return op == OP_R || op == OP_I || op == OP_LOAD || op == OP_STORE || op == OP_BRANCH;
  endfunction

  function automatic exp_t quiet(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom_range(0, 127));
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic check_val(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fails++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs, compare outputs mid-cycle, then advance past the edge.
  task automatic step(input string tag, input logic rst, input logic [6:0] op,
                      input logic [3:0] alu, input logic br, input logic ia,
                      input logic da, input exp_t e);
    exp_t got;
    rst_n = rst; i_opcode = op; i_alu_op = alu; i_br_taken = br;
    i_imem_ack = ia; i_dmem_ack = da;
    @(negedge clk);
    got = {o_state, o_imem_req, o_ir_we, o_pc_we, o_pc_sel, o_dmem_req, o_dmem_we,
           o_rf_we, o_wb_sel, o_retire, o_trap};
    n_checks++;
    if (got !== e) begin
      n_fails++;
      $display("FAIL %s @%0t: got st=%0d bits=%b want st=%0d bits=%b", tag, $time,
               got.state, got[9:0], e.state, e[9:0]);
    end
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles: the first still shows the pre-reset state, all outputs low.
  task automatic do_reset(input logic [2:0] prev);
    step("reset_first", 1'b0, r7(), r4(), rb(), rb(), rb(), quiet(prev));
    step("reset_held", 1'b0, r7(), r4(), rb(), rb(), rb(), quiet(3'd0));
  endtask

  task automatic trap_hold(input int n);
    exp_t e;
    e = quiet(3'd7);
    e.trap = 1'b1;
    for (int k = 0; k < n; k++) step("trap_hold", 1'b1, r7(), r4(), rb(), rb(), rb(), e);
  endtask

  // Expected trace of one instruction. iw/dw = wait cycles before ack;
  // abort_mem >= 0 stops before that MEM cycle so the caller can reset.
  task automatic run_instr(input logic [6:0] op, input logic [3:0] alu, input logic br,
                           input int iw, input int dw, input int abort_mem,
                           output int lat, output bit trapped, output bit aborted);
    exp_t e;
    bit   ack, alu_cls, ld, st;
    alu_cls = (op == OP_R) || (op == OP_I);
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
    lat = 0; trapped = 0; aborted = 0;

    for (int k = 0; k < TO; k++) begin
      ack = (k == iw);
      e = quiet(3'd0);
      e.imem_req = 1'b1;
      e.ir_we = ack;
      step("fetch", 1'b1, r7(), r4(), rb(), ack, rb(), e);
      lat++;
      if (ack) break;
      if (k == TO - 1) begin trapped = 1; return; end
    end

    step("decode", 1'b1, op, r4(), rb(), rb(), rb(), quiet(3'd1));
    lat++;
    if (!legal(op)) begin trapped = 1; return; end

    e = quiet(3'd2);
    if (op == OP_BRANCH) begin
      e.pc_we = 1'b1; e.pc_sel = br; e.retire = 1'b1;
    end
    step("exec", 1'b1, op, alu_cls ? alu : r4(), br, rb(), rb(), e);
    lat++;
    if (op == OP_BRANCH) return;
    if (alu_cls && alu == 4'hF) begin trapped = 1; return; end

    if (ld || st) begin
      for (int k = 0; k < TO; k++) begin
        if (k == abort_mem) begin aborted = 1; return; end
        ack = (k == dw);
        e = quiet(3'd3);
        e.dmem_req = 1'b1;
        e.dmem_we = st;
        e.pc_we = ack && st;
        e.retire = ack && st;
        step("mem", 1'b1, op, r4(), rb(), rb(), ack, e);
        lat++;
        if (ack && st) return;
        if (ack) break;
        if (k == TO - 1) begin trapped = 1; return; end
      end
    end

    e = quiet(3'd4);
    e.rf_we = 1'b1; e.wb_sel = ld; e.pc_we = 1'b1; e.retire = 1'b1;
    step("wb", 1'b1, op, r4(), rb(), rb(), rb(), e);
    lat++;
  endtask

  initial begin
    int lat;
    bit tr, ab;
    logic [6:0] op;
    rst_n = 1'b0; i_opcode = '0; i_alu_op = '0; i_br_taken = 1'b0;
    i_imem_ack = 1'b0; i_dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(3'd0);

    // Directed cases pinning latency and trap behaviour.
    run_instr(OP_R, 4'h0, 1'b0, 0, 0, -1, lat, tr, ab);
    check_val("add_latency", lat, 4);
    run_instr(OP_LOAD, 4'h0, 1'b0, 3, 2, -1, lat, tr, ab);
    check_val("lw_latency", lat, 10);
    run_instr(OP_STORE, 4'h0, 1'b0, 3, 2, -1, lat, tr, ab);
    check_val("sw_latency", lat, 9);
    run_instr(OP_BRANCH, 4'h0, 1'b1, 0, 0, -1, lat, tr, ab);
    check_val("beq_taken_latency", lat, 3);
    run_instr(OP_BRANCH, 4'h0, 1'b0, 0, 0, -1, lat, tr, ab);
    check_val("beq_not_taken_latency", lat, 3);
    run_instr(OP_I, 4'h3, 1'b0, TO - 1, 0, -1, lat, tr, ab);
    check_val("ack_on_last_cycle_no_trap", int'(tr), 0);
    check_val("ack_on_last_cycle_latency", lat, 7);

    run_instr(7'b1111111, 4'h0, 1'b0, 0, 0, -1, lat, tr, ab);
    check_val("illegal_opcode_traps", int'(tr), 1);
    trap_hold(20);
    do_reset(3'd7);

    run_instr(OP_R, 4'hF, 1'b0, 0, 0, -1, lat, tr, ab);
    check_val("illegal_alu_traps", int'(tr), 1);
    trap_hold(20);
    do_reset(3'd7);

    run_instr(OP_R, 4'h0, 1'b0, TO, 0, -1, lat, tr, ab);
    check_val("fetch_timeout_traps", int'(tr), 1);
    check_val("fetch_timeout_cycles", lat, TO);
    trap_hold(3);
    do_reset(3'd7);

    run_instr(OP_LOAD, 4'h0, 1'b0, 0, 3, 2, lat, tr, ab);
    check_val("mem_reset_abort", int'(ab), 1);
    do_reset(3'd3);

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      int kind, iw, dw, abm;
      kind = $urandom_range(0, 19);
      case (kind)
        0, 1, 2, 3: op = OP_R;
        4, 5, 6:    op = OP_I;
        7, 8, 9, 10: op = OP_LOAD;
        11, 12, 13: op = OP_STORE;
        14, 15, 16, 17: op = OP_BRANCH;
        default: begin
          op = r7();
          while (legal(op)) op = r7();
        end
      endcase
      iw  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 2);
      dw  = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 2);
      abm = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 2) : -1;
      run_instr(op, r4(), rb(), iw, dw, abm, lat, tr, ab);
      if (tr) begin
        trap_hold(3);
        do_reset(3'd7);
      end else if (ab) begin
        do_reset(3'd3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/rv32i_mc_ctrl.md
Name: rv32i_mc_ctrl

Overview:
Multi-cycle control FSM for the RV32I core. It sequences instruction fetch, decode, ALU execute, data-memory access and register writeback around the registered ALU decoder and the ALU datapath. It drives every write-enable and mux select for PC, IR, register file and memories. It traps on illegal opcodes, on illegal ALU encodings (decoder op 4'hF) and on memory-ack timeouts.

Parameters:
TIMEOUT, 255, max cycles a memory request waits for ack before trap (legal range 2..2^TO_W-1)
TO_W, 8, width of the wait counter

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
i_opcode  in  7  opcode field of IR (IR written by o_ir_we)
i_alu_op  in  4  registered ALU op from the ALU decoder; 4'hF = illegal
i_br_taken  in  1  branch compare result from ALU, valid in EXEC
i_imem_ack  in  1  instruction memory ack; read data valid this cycle
i_dmem_ack  in  1  data memory ack; load data valid / store done this cycle
o_imem_req  out  1  instruction fetch request, level, held until ack
o_ir_we  out  1  IR load strobe
o_pc_we  out  1  PC update strobe
o_pc_sel  out  1  0 = PC+4, 1 = branch target
o_dmem_req  out  1  data access request, level, held until ack
o_dmem_we  out  1  1 = store, qualifies o_dmem_req
o_rf_we  out  1  register-file write strobe
o_wb_sel  out  1  0 = ALU result, 1 = load data
o_retire  out  1  one-cycle pulse per completed instruction
o_trap  out  1  sticky fault flag
o_state  out  3  current state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. The state and wait counter are registered. All outputs except o_state are combinational decodes of state and inputs, ANDed with rst_n.
- Reset (rst_n=0 at posedge): state->FETCH, counter->0, trap->0. While rst_n=0, every output is 0 except o_state, which shows the registered state. Reset mid-request drops o_imem_req/o_dmem_req immediately, with no completion. The first cycle after release has o_imem_req=1.
- Legal opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011. Any other opcode is illegal.
- FETCH: o_imem_req=1. On i_imem_ack: o_ir_we=1 in the same cycle, then go to DECODE with counter cleared.
- DECODE: exactly 1 cycle, which gives the decoder its register stage. Legal opcode -> EXEC. Illegal opcode -> TRAP.
- EXEC:
  - R/I with i_alu_op==4'hF -> TRAP.
  - R/I otherwise -> WB.
  - LOAD/STORE -> MEM.
  - BRANCH: o_pc_we=1, o_pc_sel=i_br_taken, o_retire=1, -> FETCH.
- MEM: o_dmem_req=1, o_dmem_we=1 only for STORE. On i_dmem_ack:
  - STORE: o_pc_we=1 (sel 0), o_retire=1, -> FETCH.
  - LOAD: -> WB.
- WB: o_rf_we=1, o_wb_sel=1 for LOAD and 0 otherwise, o_pc_we=1 (sel 0), o_retire=1, -> FETCH.
- TRAP: o_trap=1. All strobes and requests are 0. TRAP is left only by reset.
- Timeout counter:
  - Increments each FETCH/MEM cycle without ack. Clears on ack and on every state change.
  - No ack in the cycle when the counter equals TIMEOUT-1 -> TRAP next edge.
  - Ack in that same cycle wins and there is no trap.
- Request rules: the request stays asserted and o_dmem_we stays stable from the first request cycle through the ack cycle. Acks that arrive outside FETCH/MEM respectively are ignored.
- Latency with zero-wait acks (cycles from the first o_imem_req cycle through the o_retire cycle):
  - R/I: 4
  - BRANCH: 3
  - STORE: 4
  - LOAD: 5
- Exactly one o_retire and one o_pc_we per instruction. o_pc_we and o_rf_we are never asserted in TRAP.

Test Plan:
- ADD (opcode 0110011, i_alu_op=0), acks tied 1 -> states 0,1,2,4; o_rf_we=1 with o_wb_sel=0, o_pc_we=1 and o_retire=1 in cycle 4; o_imem_req again in cycle 5.
- LW, i_imem_ack after 3 wait cycles, i_dmem_ack after 2 -> o_dmem_req=1 and o_dmem_we=0 held 3 cycles; WB has o_wb_sel=1; retire at cycle 4+3+2+1=10. SW with the same waits -> o_dmem_we=1 throughout MEM; retire in the ack cycle with no o_rf_we.
- BEQ with i_br_taken=1, then with i_br_taken=0 -> EXEC cycle shows o_pc_we=1 with o_pc_sel=1, then o_pc_sel=0; o_rf_we stays 0.
- Opcode 1111111 -> TRAP after DECODE. R-type with i_alu_op=4'hF -> TRAP after EXEC. In both cases o_trap=1, all strobes 0, state stays 7 through 20 further cycles and acks.
- TIMEOUT=4, i_imem_ack held 0 -> TRAP after the 4th FETCH cycle. Rerun with ack exactly in the 4th cycle -> o_ir_we=1 and no trap.
- rst_n=0 during a MEM wait -> o_dmem_req=0 immediately; after release state=0 and o_imem_req=1; o_trap cleared if previously set.
